// File: rtl/pipe_tx_width_adapter.sv
// ---------------------------------------------------------------------------
// pipe_tx_width_adapter
//
// Splits MAC-side words of IN_WIDTH bits into narrower PIPE transmit slices.
// A word is loaded into a one-word buffer. It is then emitted LSB first as
// IN_WIDTH/w slices, one per cycle with no gaps. w is the PIPE width that was
// selected when the word was loaded. Every slice carries the K flags of its
// own bytes. The start-block marker and the sync header appear only on slice 0.
//
// Ports
//   clk             : single clock; all state updates on its rising edge
//   _reset          : asynchronous, active-low reset
//   width           : PIPE width code (0=8, 1=16, 2=32, 3=64 bits per cycle)
//   in_data         : MAC-side word
//   in_data_k       : one K flag per byte of in_data
//   in_start_block  : word begins a 128b/130b block
//   in_synch_header : sync header that goes with in_start_block
//   in_valid        : in_data and its side-band fields are valid
//   in_ready        : a word can be accepted this cycle
//   tx_data         : PHY-side slice; bits above the active width are zero
//   tx_data_k       : K flags of the slice; flags above the active width are zero
//   tx_data_valid   : a slice is present this cycle
//   tx_start_block  : start-block marker (slice 0 only)
//   tx_synch_header : sync header (slice 0 only, zero otherwise)
//   width_err       : sticky; a width code wider than IN_WIDTH was loaded
// ---------------------------------------------------------------------------
module pipe_tx_width_adapter #(
   parameter int IN_WIDTH = 32
) (
   input  logic                    clk,
   input  logic                    _reset,
   input  logic [1:0]              width,
   input  logic [IN_WIDTH-1:0]     in_data,
   input  logic [IN_WIDTH/8-1:0]   in_data_k,
   input  logic                    in_start_block,
   input  logic [3:0]              in_synch_header,
   input  logic                    in_valid,
   output logic                    in_ready,
   output logic [IN_WIDTH-1:0]     tx_data,
   output logic [IN_WIDTH/8-1:0]   tx_data_k,
   output logic                    tx_data_valid,
   output logic                    tx_start_block,
   output logic [3:0]              tx_synch_header,
   output logic                    width_err
);

   localparam int         IN_BYTES = IN_WIDTH / 8;
   localparam int         CW       = $clog2(IN_BYTES);
   // The widest legal code is the one whose slice covers the whole word.
   localparam logic [1:0] MAX_CODE = 2'($clog2(IN_BYTES));

   logic [1:0]            load_code;
   logic [1:0]            act_code;
   logic                  too_wide;
   logic [IN_WIDTH-1:0]   load_dmask;
   logic [IN_WIDTH-1:0]   cur_dmask;
   logic [IN_BYTES-1:0]   load_kmask;
   logic [IN_BYTES-1:0]   cur_kmask;
   logic [CW-1:0]         load_last;
   logic [CW-1:0]         last_idx;
   logic [CW-1:0]         cnt;
   logic [IN_WIDTH-1:0]   rem_data;
   logic [IN_BYTES-1:0]   rem_k;
   logic                  busy;
   logic                  last;
   logic                  load;

   // Clamp the requested width to IN_WIDTH. Build the lane masks for the word
   // being loaded and for the word now draining. in_ready opens on the final
   // slice so that back-to-back words stream without a bubble.
   always_comb begin
      too_wide   = (width > MAX_CODE);
      load_code  = too_wide ? MAX_CODE : width;
      load_dmask = {IN_WIDTH{1'b1}} >> (IN_WIDTH - (8 << load_code));
      load_kmask = {IN_BYTES{1'b1}} >> (IN_BYTES - (1 << load_code));
      cur_dmask  = {IN_WIDTH{1'b1}} >> (IN_WIDTH - (8 << act_code));
      cur_kmask  = {IN_BYTES{1'b1}} >> (IN_BYTES - (1 << act_code));
      load_last  = CW'((IN_BYTES >> load_code) - 1);
      last       = busy && (cnt == last_idx);
      in_ready   = _reset && (!busy || last);
      load       = in_valid && in_ready;
   end

   assign tx_data_valid = busy;

   // Slice 0 goes straight to the output registers at load time. The rest of
   // the word is kept pre-shifted in rem_data/rem_k, so each later slice is
   // always taken from the bottom lanes of the buffer.
   always_ff @(posedge clk or negedge _reset) begin
      if (!_reset) begin
         busy            <= 1'b0;
         cnt             <= '0;
         last_idx        <= '0;
         act_code        <= 2'd0;
         rem_data        <= '0;
         rem_k           <= '0;
         tx_data         <= '0;
         tx_data_k       <= '0;
         tx_start_block  <= 1'b0;
         tx_synch_header <= 4'd0;
         width_err       <= 1'b0;
      end else if (load) begin
         busy            <= 1'b1;
         cnt             <= '0;
         last_idx        <= load_last;
         act_code        <= load_code;
         tx_data         <= in_data & load_dmask;
         tx_data_k       <= in_data_k & load_kmask;
         rem_data        <= in_data >> (8 << load_code);
         rem_k           <= in_data_k >> (1 << load_code);
         tx_start_block  <= in_start_block;
         tx_synch_header <= in_synch_header;
         if (too_wide) begin
            width_err <= 1'b1;
         end
      end else if (busy && !last) begin
         cnt             <= cnt + CW'(1);
         tx_data         <= rem_data & cur_dmask;
         tx_data_k       <= rem_k & cur_kmask;
         rem_data        <= rem_data >> (8 << act_code);
         rem_k           <= rem_k >> (1 << act_code);
         tx_start_block  <= 1'b0;
         tx_synch_header <= 4'd0;
      end else begin
         busy            <= 1'b0;
         cnt             <= '0;
         tx_data         <= '0;
         tx_data_k       <= '0;
         tx_start_block  <= 1'b0;
         tx_synch_header <= 4'd0;
      end
   end

endmodule
